// File: rtl/rpn_pkg.sv
// Shared constants and types for the RPN stack viewer.
package rpn_pkg;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned PTR_W = 3;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned TMO_W = 4;
   localparam int unsigned SEG_W = 7;

   localparam logic [TMO_W-1:0] TIMEOUT   = 4'd15;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, SHOW} state_e;

   // Registered display contents: value digits and depth-offset digit.
   typedef struct packed {
      logic [SEG_W-1:0] hex1;
      logic [SEG_W-1:0] hex0;
      logic [SEG_W-1:0] hex4;
   } disp_t;

endpackage

// File: rtl/hex7seg.sv
// Nibble to active-low seven-segment pattern, segment order {g,f,e,d,c,b,a}.
module hex7seg
   import rpn_pkg::*;
(
   input  logic [3:0]       nib,
   output logic [SEG_W-1:0] seg_c
);

   always_comb begin
      seg_c = SEG_BLANK;
      case (nib)
         4'h0: seg_c = 7'b1000000;
         4'h1: seg_c = 7'b1111001;
         4'h2: seg_c = 7'b0100100;
         4'h3: seg_c = 7'b0110000;
         4'h4: seg_c = 7'b0011001;
         4'h5: seg_c = 7'b0010010;
         4'h6: seg_c = 7'b0000010;
         4'h7: seg_c = 7'b1111000;
         4'h8: seg_c = 7'b0000000;
         4'h9: seg_c = 7'b0010000;
         4'hA: seg_c = 7'b0001000;
         4'hB: seg_c = 7'b0000011;
         4'hC: seg_c = 7'b1000110;
         4'hD: seg_c = 7'b0100001;
         4'hE: seg_c = 7'b0000110;
         4'hF: seg_c = 7'b0001110;
         default: seg_c = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/rpn_stack_viewer.sv
// Browses the RPN operand stack with two keys, fetches the selected entry
// over a one-cycle read port and shows it on the seven-segment displays.
module rpn_stack_viewer
   import rpn_pkg::*;
(
   input  logic             CLOCK_50,
   input  logic             rst_n,
   input  logic             key_up_n,
   input  logic             key_dn_n,
   input  logic [PTR_W:0]   count,
   input  logic             stack_changed,
   output logic             rd_req,
   output logic [PTR_W-1:0] rd_addr,
   input  logic             rd_valid,
   input  logic [WIDTH-1:0] rd_data,
   output logic [SEG_W-1:0] HEX0,
   output logic [SEG_W-1:0] HEX1,
   output logic [SEG_W-1:0] HEX2,
   output logic [SEG_W-1:0] HEX3,
   output logic [SEG_W-1:0] HEX4,
   output logic [SEG_W-1:0] HEX5,
   output logic [PTR_W-1:0] view_offset,
   output logic             err
);

   localparam disp_t DISP_RST = '{hex1: SEG_BLANK, hex0: SEG_BLANK, hex4: SEG_BLANK};

   state_e           state_q, state_d;
   logic [2:0]       up_sync_q, up_sync_d, dn_sync_q, dn_sync_d;
   logic [PTR_W-1:0] offset_q, offset_d;
   logic [PTR_W-1:0] req_off_q, req_off_d;
   logic [PTR_W-1:0] rd_addr_q, rd_addr_d;
   logic             pend_q, pend_d;
   logic             rd_req_q, rd_req_d;
   logic             err_q, err_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   disp_t            disp_q, disp_d;

   logic             up_pulse_c, dn_pulse_c;
   logic [PTR_W-1:0] last_c;
   logic [SEG_W-1:0] seg_hi_c, seg_lo_c, seg_off_c;

   hex7seg u_seg_hi  (.nib(rd_data[7:4]),   .seg_c(seg_hi_c));
   hex7seg u_seg_lo  (.nib(rd_data[3:0]),   .seg_c(seg_lo_c));
   hex7seg u_seg_off (.nib(4'(req_off_q)),  .seg_c(seg_off_c));

   // Bits [1:0] synchronise the raw key, bit 2 remembers the previous level.
   assign up_sync_d  = {up_sync_q[1:0], key_up_n};
   assign dn_sync_d  = {dn_sync_q[1:0], key_dn_n};
   assign up_pulse_c = up_sync_q[2] & ~up_sync_q[1];
   assign dn_pulse_c = dn_sync_q[2] & ~dn_sync_q[1];
   assign last_c     = PTR_W'(count - CNT_W'(1));

   always_comb begin
      state_d   = state_q;
      offset_d  = offset_q;
      pend_d    = pend_q;
      rd_req_d  = 1'b0;
      rd_addr_d = rd_addr_q;
      req_off_d = req_off_q;
      tmo_d     = tmo_q;
      err_d     = err_q;
      disp_d    = disp_q;

      // Outputs are computed for the state being entered, so rd_req is
      // high exactly while the FSM sits in REQ.
      case (state_q)
         IDLE: begin
            if (pend_q) begin
               pend_d = 1'b0;
               if (count == '0) begin
                  disp_d = '{hex1: SEG_DASH, hex0: SEG_DASH, hex4: SEG_DASH};
               end else begin
                  state_d   = REQ;
                  rd_req_d  = 1'b1;
                  rd_addr_d = PTR_W'(last_c - offset_q);
                  req_off_d = offset_q;
                  tmo_d     = '0;
               end
            end
         end
         REQ: begin
            state_d = WAIT;
            tmo_d   = TMO_W'(tmo_q + 1'b1);
         end
         WAIT: begin
            if (rd_valid) begin
               state_d = SHOW;
               err_d   = 1'b0;
               disp_d  = '{hex1: seg_hi_c, hex0: seg_lo_c, hex4: seg_off_c};
            end else if (tmo_q == TIMEOUT) begin
               state_d     = IDLE;
               err_d       = 1'b1;
               disp_d.hex1 = SEG_DASH;
               disp_d.hex0 = SEG_DASH;
            end else begin
               tmo_d = TMO_W'(tmo_q + 1'b1);
            end
         end
         SHOW:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Browse events come last so a request raised mid-read survives.
      if (stack_changed) begin
         offset_d = '0;
         pend_d   = 1'b1;
      end else if (count == '0) begin
         offset_d = '0;
      end else if (up_pulse_c ^ dn_pulse_c) begin
         if (up_pulse_c) begin
            offset_d = (offset_q == last_c) ? '0 : PTR_W'(offset_q + 1'b1);
         end else begin
            offset_d = (offset_q == '0) ? last_c : PTR_W'(offset_q - 1'b1);
         end
         if (offset_d != offset_q) pend_d = 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         up_sync_q <= '1;
         dn_sync_q <= '1;
         offset_q  <= '0;
         req_off_q <= '0;
         rd_addr_q <= '0;
         pend_q    <= 1'b1;
         rd_req_q  <= 1'b0;
         err_q     <= 1'b0;
         tmo_q     <= '0;
         disp_q    <= DISP_RST;
      end else begin
         state_q   <= state_d;
         up_sync_q <= up_sync_d;
         dn_sync_q <= dn_sync_d;
         offset_q  <= offset_d;
         req_off_q <= req_off_d;
         rd_addr_q <= rd_addr_d;
         pend_q    <= pend_d;
         rd_req_q  <= rd_req_d;
         err_q     <= err_d;
         tmo_q     <= tmo_d;
         disp_q    <= disp_d;
      end
   end

   assign rd_req      = rd_req_q;
   assign rd_addr     = rd_addr_q;
   assign view_offset = offset_q;
   assign err         = err_q;
   assign HEX0        = disp_q.hex0;
   assign HEX1        = disp_q.hex1;
   assign HEX4        = disp_q.hex4;
   assign HEX2        = SEG_BLANK;
   assign HEX3        = SEG_BLANK;
   assign HEX5        = SEG_BLANK;

endmodule

// File: tb/tb_rpn_stack_viewer.sv
// Scoreboard bench for rpn_stack_viewer: stimulus queues expected reads and
// display updates, a negedge monitor pops them as the DUT produces them.
`timescale 1ns/1ps
module tb_rpn_stack_viewer;

   localparam logic [6:0] S_0 = 7'h40, S_1 = 7'h79, S_2 = 7'h24, S_3 = 7'h30;
   localparam logic [6:0] S_5 = 7'h12, S_8 = 7'h00, S_A = 7'h08, S_C = 7'h46;
   localparam logic [6:0] S_E = 7'h06, S_F = 7'h0E, S_D = 7'h3F, S_B = 7'h7F;

   typedef struct packed {
      logic       e;
      logic [6:0] h1;
      logic [6:0] h0;
      logic [6:0] h4;
   } disp_s;

   typedef struct {
      disp_s v;
      int    lat;
   } dexp_t;

   logic       CLOCK_50;
   logic       rst_n;
   logic       key_up_n, key_dn_n;
   logic [3:0] count;
   logic       stack_changed;
   logic       rd_req;
   logic [2:0] rd_addr;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
   logic [2:0] view_offset;
   logic       err;

   rpn_stack_viewer dut (
      .CLOCK_50(CLOCK_50), .rst_n(rst_n), .key_up_n(key_up_n), .key_dn_n(key_dn_n),
      .count(count), .stack_changed(stack_changed), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_valid(rd_valid), .rd_data(rd_data), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
      .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5), .view_offset(view_offset), .err(err)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   int    req_cyc = 0;
   int    addr_q[$];
   dexp_t disp_q[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Memory model: answers rd_req after lat cycles unless withheld.
   logic [7:0] mem [0:7];
   int         lat = 1;
   bit         withhold = 1'b0;
   bit         mpend;
   int         dly;
   logic [2:0] raddr;

   always @(posedge CLOCK_50) begin
      rd_valid <= 1'b0;
      if (rd_req && !withhold) begin
         if (lat <= 1) begin
            rd_valid <= 1'b1;
            rd_data  <= mem[rd_addr];
         end else begin
            mpend <= 1'b1;
            dly   <= lat - 1;
            raddr <= rd_addr;
         end
      end else if (mpend) begin
         if (dly <= 1) begin
            rd_valid <= 1'b1;
            rd_data  <= mem[raddr];
            mpend    <= 1'b0;
         end else begin
            dly <= dly - 1;
         end
      end
   end

   // Monitor: checks every read strobe and every display change.
   disp_s prev_d, cur_d;
   always @(negedge CLOCK_50) begin
      cyc++;
      cur_d = {err, HEX1, HEX0, HEX4};
      if (!rst_n) begin
         prev_d = cur_d;
      end else begin
         if (rd_req) begin
            req_cyc = cyc;
            if (addr_q.size() == 0) check("unexpected_rd_req", 32'(rd_addr), 32'hFFFF_FFFF);
            else check("rd_addr", 32'(rd_addr), 32'(addr_q.pop_front()));
         end
         if (cur_d != prev_d) begin
            if (disp_q.size() == 0) begin
               check("unexpected_display", 32'(cur_d), 32'(prev_d));
            end else begin
               dexp_t e;
               e = disp_q.pop_front();
               check("display", 32'(cur_d), 32'(e.v));
               if (e.lat >= 0) check("display_latency", 32'(cyc - req_cyc), 32'(e.lat));
            end
         end
         prev_d = cur_d;
      end
   end

   task automatic exp_disp(input disp_s v, input int l);
      dexp_t e;
      e.v   = v;
      e.lat = l;
      disp_q.push_back(e);
   endtask

   task automatic exp_read(input int a, input disp_s v);
      addr_q.push_back(a);
      exp_disp(v, lat + 1);
   endtask

   task automatic pulse_sc();
      @(negedge CLOCK_50);
      stack_changed = 1'b1;
      @(negedge CLOCK_50);
      stack_changed = 1'b0;
   endtask

   task automatic press(input bit up, input int hold);
      @(negedge CLOCK_50);
      if (up) key_up_n = 1'b0;
      else    key_dn_n = 1'b0;
      repeat (hold) @(negedge CLOCK_50);
      key_up_n = 1'b1;
      key_dn_n = 1'b1;
      repeat (15) @(negedge CLOCK_50);
   endtask

   task automatic wait_req();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLOCK_50);
         if (rd_req) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("wait_rd_req_timeout", 32'd0, 32'd1);
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 8'h00;
      rst_n = 1'b1; key_up_n = 1'b1; key_dn_n = 1'b1;
      count = 4'd0; stack_changed = 1'b0;
      #2 rst_n = 1'b0;

      // Reset state, then empty stack shows dashes and never reads
      settle(2);
      check("rst_hex0", 32'(HEX0), 32'(S_B));
      check("rst_hex1", 32'(HEX1), 32'(S_B));
      check("rst_hex4", 32'(HEX4), 32'(S_B));
      check("rst_rd_req", 32'(rd_req), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_view_offset", 32'(view_offset), 32'd0);
      exp_disp({1'b0, S_D, S_D, S_D}, -1);
      rst_n = 1'b1;
      settle(20);
      check("hex2_blank", 32'(HEX2), 32'(S_B));
      check("hex3_blank", 32'(HEX3), 32'(S_B));
      check("hex5_blank", 32'(HEX5), 32'(S_B));
      check("err_empty", 32'(err), 32'd0);

      // Single entry
      count = 4'd1; mem[0] = 8'hAE;
      exp_read(0, {1'b0, S_A, S_E, S_0});
      pulse_sc();
      settle(20);

      // Three entries, browse up with wrap, then a long hold
      count = 4'd3; mem[1] = 8'h83; mem[2] = 8'h83;
      exp_read(2, {1'b0, S_8, S_3, S_0});
      pulse_sc();
      settle(20);
      exp_read(1, {1'b0, S_8, S_3, S_1});
      press(1'b1, 5);
      check("up1_offset", 32'(view_offset), 32'd1);
      exp_read(0, {1'b0, S_A, S_E, S_2});
      press(1'b1, 5);
      check("up2_offset", 32'(view_offset), 32'd2);
      exp_read(2, {1'b0, S_8, S_3, S_0});
      press(1'b1, 5);
      check("up3_offset_wrap", 32'(view_offset), 32'd0);
      exp_read(1, {1'b0, S_8, S_3, S_1});
      press(1'b1, 100);
      check("hold_offset", 32'(view_offset), 32'd1);

      // Down from 1 to 0, then wrap down to count-1
      exp_read(2, {1'b0, S_8, S_3, S_0});
      press(1'b0, 5);
      check("dn1_offset", 32'(view_offset), 32'd0);
      exp_read(0, {1'b0, S_A, S_E, S_2});
      press(1'b0, 5);
      check("dn2_offset_wrap", 32'(view_offset), 32'd2);

      // Read timeout, then recovery
      withhold = 1'b1;
      addr_q.push_back(2);
      exp_disp({1'b1, S_D, S_D, S_2}, 16);
      pulse_sc();
      settle(30);
      check("timeout_err", 32'(err), 32'd1);
      withhold = 1'b0; mem[2] = 8'hFF;
      exp_read(2, {1'b0, S_F, S_F, S_0});
      pulse_sc();
      settle(20);
      check("recover_err", 32'(err), 32'd0);

      // stack_changed and key pulse together while a slow read is in flight
      mem[2] = 8'h5C; lat = 6;
      exp_read(2, {1'b0, S_5, S_C, S_0});
      pulse_sc();
      wait_req();
      key_up_n = 1'b0;
      settle(2);
      stack_changed = 1'b1; count = 4'd4; mem[3] = 8'h21;
      exp_read(3, {1'b0, S_2, S_1, S_0});
      @(negedge CLOCK_50);
      stack_changed = 1'b0;
      settle(5);
      key_up_n = 1'b1;
      settle(30);
      check("collide_offset", 32'(view_offset), 32'd0);
      lat = 1;

      // Reset while waiting for read data
      withhold = 1'b1;
      addr_q.push_back(3);
      pulse_sc();
      wait_req();
      @(negedge CLOCK_50);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_rd_req", 32'(rd_req), 32'd0);
      check("midrst_hex", 32'({HEX0, HEX1, HEX4}), 32'({S_B, S_B, S_B}));
      check("midrst_err", 32'(err), 32'd0);
      check("midrst_view_offset", 32'(view_offset), 32'd0);
      withhold = 1'b0;
      settle(2);
      exp_read(3, {1'b0, S_2, S_1, S_0});
      rst_n = 1'b1;
      settle(30);

      check("addr_queue_drained", 32'(addr_q.size()), 32'd0);
      check("disp_queue_drained", 32'(disp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
